// File: rtl/ssd_scan_ctrl.sv
// Multiplexed seven-segment scan controller: double-buffered digit data with a
// frame-aligned load handshake, blanking/blink/leading-zero suppression and PWM dimming.
module ssd_scan_ctrl #(
  parameter int NUM_DIGITS   = 8,
  parameter int DIV          = 100000,
  parameter int BRIGHT_BITS  = 3,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_value,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic                    lz_blank,
  input  logic [BRIGHT_BITS-1:0]  brightness,
  input  logic                    load,
  output logic                    load_done,
  output logic                    frame_start,
  output logic [6:0]              display,
  output logic                    DP,
  output logic [NUM_DIGITS-1:0]   AN
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int VW    = 4 * NUM_DIGITS;

  function automatic logic [6:0] hex_font(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [BLK_W-1:0]       blink_cnt_q, blink_cnt_d;
  logic                   blink_q, blink_d;
  logic                   pend_q, pend_d;

  logic [VW-1:0]          stg_value_q, stg_value_d;
  logic [NUM_DIGITS-1:0]  stg_dp_q, stg_dp_d;
  logic [NUM_DIGITS-1:0]  stg_blank_q, stg_blank_d;
  logic [NUM_DIGITS-1:0]  stg_blink_q, stg_blink_d;
  logic                   stg_lz_q, stg_lz_d;
  logic [BRIGHT_BITS-1:0] stg_bright_q, stg_bright_d;

  logic [VW-1:0]          act_value_q, act_value_d;
  logic [NUM_DIGITS-1:0]  act_dp_q, act_dp_d;
  logic [NUM_DIGITS-1:0]  act_blank_q, act_blank_d;
  logic [NUM_DIGITS-1:0]  act_blink_q, act_blink_d;
  logic                   act_lz_q, act_lz_d;
  logic [BRIGHT_BITS-1:0] act_bright_q, act_bright_d;

  logic [NUM_DIGITS-1:0]  an_q, an_d;
  logic [6:0]             seg_q, seg_d;
  logic                   dp_q, dp_d;
  logic                   load_done_q, load_done_d;
  logic                   frame_start_q, frame_start_d;

  logic                   slot_end, frame_end;
  logic [NUM_DIGITS-1:0]  lz_mask;
  logic                   zero_run;
  logic                   dark;
  logic [3:0]             dig_nib;
  logic [31:0]            on_len;

  // A digit is a suppressible leading zero when it and every digit above it are zero.
  always_comb begin
    lz_mask  = '0;
    zero_run = 1'b1;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      zero_run = zero_run & (act_value_q[4*(NUM_DIGITS-1-k) +: 4] == 4'h0);
      lz_mask[NUM_DIGITS-1-k] = zero_run & (k != NUM_DIGITS-1);
    end
  end

  always_comb begin
    slot_end  = (cnt_q == CNT_W'(DIV - 1));
    frame_end = slot_end && (idx_q == IDX_W'(NUM_DIGITS - 1));

    cnt_d = slot_end ? '0 : cnt_q + CNT_W'(1);
    idx_d = idx_q;
    if (slot_end) idx_d = frame_end ? '0 : idx_q + IDX_W'(1);

    blink_cnt_d = blink_cnt_q;
    blink_d     = blink_q;
    if (frame_end) begin
      if (blink_cnt_q == BLK_W'(BLINK_FRAMES - 1)) begin
        blink_cnt_d = '0;
        blink_d     = ~blink_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BLK_W'(1);
      end
    end

    stg_value_d  = stg_value_q;
    stg_dp_d     = stg_dp_q;
    stg_blank_d  = stg_blank_q;
    stg_blink_d  = stg_blink_q;
    stg_lz_d     = stg_lz_q;
    stg_bright_d = stg_bright_q;
    if (load) begin
      stg_value_d  = value;
      stg_dp_d     = dp_value;
      stg_blank_d  = blank_mask;
      stg_blink_d  = blink_mask;
      stg_lz_d     = lz_blank;
      stg_bright_d = brightness;
    end

    act_value_d  = act_value_q;
    act_dp_d     = act_dp_q;
    act_blank_d  = act_blank_q;
    act_blink_d  = act_blink_q;
    act_lz_d     = act_lz_q;
    act_bright_d = act_bright_q;
    pend_d       = pend_q;
    // A load landing on the boundary itself bypasses staging and supersedes any pending set.
    if (frame_end) begin
      pend_d = 1'b0;
      if (load) begin
        act_value_d  = value;
        act_dp_d     = dp_value;
        act_blank_d  = blank_mask;
        act_blink_d  = blink_mask;
        act_lz_d     = lz_blank;
        act_bright_d = brightness;
      end else if (pend_q) begin
        act_value_d  = stg_value_q;
        act_dp_d     = stg_dp_q;
        act_blank_d  = stg_blank_q;
        act_blink_d  = stg_blink_q;
        act_lz_d     = stg_lz_q;
        act_bright_d = stg_bright_q;
      end
    end else if (load) begin
      pend_d = 1'b1;
    end
    load_done_d = frame_end && (load || pend_q);
  end

  always_comb begin
    dig_nib = act_value_q[{idx_q, 2'b00} +: 4];
    dark    = act_blank_q[idx_q]
            | (act_blink_q[idx_q] & blink_q)
            | (act_lz_q & lz_mask[idx_q]);
    on_len  = ((32'(act_bright_q) + 32'd1) * 32'(DIV)) >> BRIGHT_BITS;

    an_d = '1;
    if (!dark && (32'(cnt_q) < on_len)) an_d[idx_q] = 1'b0;
    seg_d         = dark ? 7'h7F : hex_font(dig_nib);
    dp_d          = ~(act_dp_q[idx_q] & ~dark);
    frame_start_d = (idx_q == '0) && (cnt_q == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q         <= '0;
      idx_q         <= '0;
      blink_cnt_q   <= '0;
      blink_q       <= 1'b0;
      pend_q        <= 1'b0;
      stg_value_q   <= '0;
      stg_dp_q      <= '0;
      stg_blank_q   <= '0;
      stg_blink_q   <= '0;
      stg_lz_q      <= 1'b0;
      stg_bright_q  <= '1;
      act_value_q   <= '0;
      act_dp_q      <= '0;
      act_blank_q   <= '0;
      act_blink_q   <= '0;
      act_lz_q      <= 1'b0;
      act_bright_q  <= '1;
      an_q          <= '1;
      seg_q         <= 7'h7F;
      dp_q          <= 1'b1;
      load_done_q   <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_q       <= blink_d;
      pend_q        <= pend_d;
      stg_value_q   <= stg_value_d;
      stg_dp_q      <= stg_dp_d;
      stg_blank_q   <= stg_blank_d;
      stg_blink_q   <= stg_blink_d;
      stg_lz_q      <= stg_lz_d;
      stg_bright_q  <= stg_bright_d;
      act_value_q   <= act_value_d;
      act_dp_q      <= act_dp_d;
      act_blank_q   <= act_blank_d;
      act_blink_q   <= act_blink_d;
      act_lz_q      <= act_lz_d;
      act_bright_q  <= act_bright_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      load_done_q   <= load_done_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign AN          = an_q;
  assign display     = seg_q;
  assign DP          = dp_q;
  assign load_done   = load_done_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Bench for ssd_scan_ctrl: directed and random loads checked every cycle against a
// frame/slot arithmetic model of the scanner.
module tb_ssd_scan_ctrl;
  localparam int N  = 4;
  localparam int DV = 8;
  localparam int BB = 2;
  localparam int BF = 2;
  localparam int FRAME = N * DV;

  typedef struct packed {
    logic [15:0] value;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic [3:0]  blink;
    logic        lz;
    logic [1:0]  bright;
  } cfg_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp_value = '0, blank_mask = '0, blink_mask = '0;
  logic        lz_blank = 1'b0;
  logic [1:0]  brightness = '1;
  logic        load = 1'b0;
  logic        load_done, frame_start, DP;
  logic [6:0]  display;
  logic [3:0]  AN;

  ssd_scan_ctrl #(.NUM_DIGITS(N), .DIV(DV), .BRIGHT_BITS(BB), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .rst_n(rst_n), .value(value), .dp_value(dp_value),
    .blank_mask(blank_mask), .blink_mask(blink_mask), .lz_blank(lz_blank),
    .brightness(brightness), .load(load), .load_done(load_done),
    .frame_start(frame_start), .display(display), .DP(DP), .AN(AN)
  );

  always #5 clk = ~clk;

  int          n_assert = 0;
  int          n_fail = 0;
  int unsigned t;
  int          ld_seen;
  cfg_t        act_m, stg_m, cur_in;
  bit          pend_m;

  function automatic logic [6:0] font_of(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
      4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
      4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
      4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_an"}, 32'(AN), 32'hF);
    chk({tag, "_display"}, 32'(display), 32'h7F);
    chk({tag, "_dp"}, 32'(DP), 32'h1);
    chk({tag, "_load_done"}, 32'(load_done), 32'h0);
    chk({tag, "_frame_start"}, 32'(frame_start), 32'h0);
  endtask

  task automatic model_reset();
    t      = 0;
    act_m  = '{value: 16'h0, dp: 4'h0, blank: 4'h0, blink: 4'h0, lz: 1'b0, bright: 2'b11};
    stg_m  = act_m;
    pend_m = 1'b0;
  endtask

  task automatic apply(input cfg_t c);
    value      = c.value;
    dp_value   = c.dp;
    blank_mask = c.blank;
    blink_mask = c.blink;
    lz_blank   = c.lz;
    brightness = c.bright;
  endtask

  // One clock: predict outputs from the slot/frame position, step, compare, advance model.
  task automatic cycle();
    int unsigned d, c, frame;
    bit          phase, dark, lit, bnd, l_in;
    logic [3:0]  exp_an;
    logic [6:0]  exp_seg;
    logic        exp_dp, exp_fs, exp_ld;
    d     = (t / DV) % N;
    c     = t % DV;
    frame = t / FRAME;
    phase = ((frame / BF) % 2) == 1;
    bnd   = (t % FRAME) == FRAME - 1;
    l_in  = load;
    dark  = act_m.blank[d] || (act_m.blink[d] && phase) ||
            (act_m.lz && d > 0 && (act_m.value >> (4 * d)) == 16'h0);
    lit   = !dark && c < ((int'(act_m.bright) + 1) * DV) / (1 << BB);
    exp_an  = lit ? ~(4'b0001 << d) : 4'hF;
    exp_seg = dark ? 7'h7F : font_of(4'((act_m.value >> (4 * d)) & 16'hF));
    exp_dp  = !(act_m.dp[d] && !dark);
    exp_fs  = (t % FRAME) == 0;
    exp_ld  = bnd && (l_in || pend_m);
    @(posedge clk);
    #1;
    chk("an", 32'(AN), 32'(exp_an));
    chk("display", 32'(display), 32'(exp_seg));
    chk("dp", 32'(DP), 32'(exp_dp));
    chk("frame_start", 32'(frame_start), 32'(exp_fs));
    chk("load_done", 32'(load_done), 32'(exp_ld));
    if (load_done === 1'b1) ld_seen++;
    if (bnd) begin
      if (l_in) act_m = cur_in;
      else if (pend_m) act_m = stg_m;
      pend_m = 1'b0;
    end else if (l_in) begin
      stg_m  = cur_in;
      pend_m = 1'b1;
    end
    t++;
    load = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic run_to_slot(input int unsigned pos);
    for (int i = 0; i < FRAME && (t % FRAME) != pos; i++) cycle();
  endtask

  task automatic do_load(input cfg_t c);
    cur_in = c;
    apply(c);
    load = 1'b1;
    cycle();
  endtask

  function automatic cfg_t mk(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] bl,
                              input logic [3:0] bk, input logic lz, input logic [1:0] br);
    cfg_t c;
    c = '{value: v, dp: dp, blank: bl, blink: bk, lz: lz, bright: br};
    return c;
  endfunction

  initial begin
    int   ld_base;
    cfg_t rc;
    logic [15:0] vmask;
    model_reset();
    ld_seen = 0;
    #12;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Idle scan after reset, inputs wiggled without load must not matter.
    run(20);
    apply(mk(16'hFFFF, 4'hF, 4'hF, 4'hF, 1'b1, 2'b00));
    run(50);

    // Mid-frame load at slot position 5, visible only after the boundary.
    run_to_slot(5);
    do_load(mk(16'h12AF, 4'h0, 4'h0, 4'h0, 1'b0, 2'b11));
    run(FRAME + 8);
    chk("font_digit0_F", 32'(act_m.value[3:0]), 32'hF);

    // Two loads in one frame: single load_done, second data wins.
    run_to_slot(3);
    ld_base = ld_seen;
    do_load(mk(16'h1111, 4'h0, 4'h0, 4'h0, 1'b0, 2'b11));
    run_to_slot(20);
    do_load(mk(16'hBEEF, 4'h0, 4'h0, 4'h0, 1'b0, 2'b11));
    run(FRAME + 4);
    chk("double_load_pulses", 32'(ld_seen - ld_base), 32'd1);

    // Load on the boundary cycle itself.
    run_to_slot(FRAME - 1);
    do_load(mk(16'h5678, 4'h0, 4'h0, 4'h0, 1'b0, 2'b11));
    run(FRAME);

    // Leading-zero suppression.
    do_load(mk(16'h0040, 4'h0, 4'h0, 4'h0, 1'b1, 2'b11));
    run(2 * FRAME);
    do_load(mk(16'h0000, 4'h0, 4'h0, 4'h0, 1'b1, 2'b11));
    run(2 * FRAME);

    // Brightness sweep.
    for (int b = 0; b < 4; b++) begin
      do_load(mk(16'h3C96, 4'h0, 4'h0, 4'h0, 1'b0, 2'(b)));
      run(2 * FRAME);
    end

    // Blink, blank and DP together over several blink periods.
    do_load(mk(16'h8421, 4'b0001, 4'b1000, 4'b0010, 1'b0, 2'b11));
    run(6 * FRAME);

    // Random loads and input noise.
    for (int i = 0; i < 1500; i++) begin
      case ($urandom_range(3, 0))
        0: vmask = 16'hFFFF;
        1: vmask = 16'h00FF;
        2: vmask = 16'h000F;
        default: vmask = 16'h0000;
      endcase
      rc = mk(16'($urandom) & vmask, 4'($urandom), 4'($urandom) & 4'($urandom),
              4'($urandom), 1'($urandom), 2'($urandom));
      if ($urandom_range(15, 0) == 0) do_load(rc);
      else begin
        apply(rc);
        cycle();
      end
    end

    // Async reset mid-frame with a load still pending.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    run(10);
    do_load(mk(16'h9ABC, 4'hF, 4'h0, 4'h0, 1'b0, 2'b00));
    run(2);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async_reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    ld_base = ld_seen;
    run(2 * FRAME + 5);
    chk("pending_discarded", 32'(ld_seen - ld_base), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
